// File: rtl/subtrator_multibyte_seq.sv
// Multi-byte subtraction controller: steps an external 8-bit ripple-borrow subtractor
// one byte per clock, LSB first, chaining the borrow between passes.
module subtrator_multibyte_seq #(
    parameter int unsigned N_BYTES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 iniciar,
    input  logic [8*N_BYTES-1:0] op_a,
    input  logic [8*N_BYTES-1:0] op_b,
    input  logic                 bin_ext,
    output logic [7:0]           sub_a,
    output logic [7:0]           sub_b,
    output logic                 sub_bin,
    input  logic [7:0]           sub_s,
    input  logic                 sub_bout,
    output logic [8*N_BYTES-1:0] resultado,
    output logic                 borrow_final,
    output logic                 zero,
    output logic                 ocupado,
    output logic                 pronto
);

    localparam int unsigned W  = 8 * N_BYTES;
    localparam int unsigned IW = $clog2(N_BYTES);
    localparam logic [IW-1:0] LAST = IW'(N_BYTES - 1);

    typedef enum logic [1:0] {OCIOSO, CALC, FIM} estado_t;

    estado_t       estado;
    logic [W-1:0]  reg_a;
    logic [W-1:0]  reg_b;
    logic          borrow;
    logic [IW-1:0] idx;
    logic [W-1:0]  res_next;
    logic          start;

    // The FIM exit edge also samples iniciar so back-to-back operations
    // sustain one result every N_BYTES+1 clocks.
    assign start = iniciar && (estado == OCIOSO || estado == FIM);

    always_comb begin
        res_next = resultado;
        res_next[8*idx +: 8] = sub_s;
    end

    always_comb begin
        sub_a   = '0;
        sub_b   = '0;
        sub_bin = 1'b0;
        if (estado == CALC) begin
            sub_a   = reg_a[8*idx +: 8];
            sub_b   = reg_b[8*idx +: 8];
            sub_bin = borrow;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado       <= OCIOSO;
            reg_a        <= '0;
            reg_b        <= '0;
            borrow       <= 1'b0;
            idx          <= '0;
            resultado    <= '0;
            borrow_final <= 1'b0;
            zero         <= 1'b0;
            ocupado      <= 1'b0;
            pronto       <= 1'b0;
        end else begin
            pronto <= 1'b0;
            if (start) begin
                estado       <= CALC;
                reg_a        <= op_a;
                reg_b        <= op_b;
                borrow       <= bin_ext;
                idx          <= '0;
                resultado    <= '0;
                borrow_final <= 1'b0;
                zero         <= 1'b0;
                ocupado      <= 1'b1;
            end else begin
                case (estado)
                    CALC: begin
                        resultado <= res_next;
                        borrow    <= sub_bout;
                        if (idx == LAST) begin
                            estado       <= FIM;
                            borrow_final <= sub_bout;
                            zero         <= (res_next == '0);
                            pronto       <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                    FIM: begin
                        estado  <= OCIOSO;
                        ocupado <= 1'b0;
                    end
                    default: estado <= OCIOSO;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_subtrator_multibyte_seq.sv
// Bench for subtrator_multibyte_seq: N_BYTES=2 directed cases and an N_BYTES=4 random
// regression, each DUT wrapped around a behavioural 8-bit subtractor.
module tb_subtrator_multibyte_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // N_BYTES = 2 instance
    logic        iniciar2, bin2;
    logic [15:0] op_a2, op_b2, res2;
    logic [7:0]  sa2, sb2, ss2;
    logic        sbin2, sbout2, bf2, zero2, oc2, pr2;

    // N_BYTES = 4 instance
    logic        iniciar4, bin4;
    logic [31:0] op_a4, op_b4, res4;
    logic [7:0]  sa4, sb4, ss4;
    logic        sbin4, sbout4, bf4, zero4, oc4, pr4;

    assign {sbout2, ss2} = {1'b0, sa2} - {1'b0, sb2} - {8'd0, sbin2};
    assign {sbout4, ss4} = {1'b0, sa4} - {1'b0, sb4} - {8'd0, sbin4};

    subtrator_multibyte_seq #(.N_BYTES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .iniciar(iniciar2), .op_a(op_a2), .op_b(op_b2),
        .bin_ext(bin2), .sub_a(sa2), .sub_b(sb2), .sub_bin(sbin2), .sub_s(ss2),
        .sub_bout(sbout2), .resultado(res2), .borrow_final(bf2), .zero(zero2),
        .ocupado(oc2), .pronto(pr2)
    );

    subtrator_multibyte_seq #(.N_BYTES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .iniciar(iniciar4), .op_a(op_a4), .op_b(op_b4),
        .bin_ext(bin4), .sub_a(sa4), .sub_b(sb4), .sub_bin(sbin4), .sub_s(ss4),
        .sub_bout(sbout4), .resultado(res4), .borrow_final(bf4), .zero(zero4),
        .ocupado(oc4), .pronto(pr4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One N_BYTES=2 operation, expected values from plain integer arithmetic.
    task automatic d2(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic bin, input bit chk_b0);
        longint diff;
        int     n;
        diff = longint'(a) - longint'(b) - longint'(bin);
        op_a2 = a; op_b2 = b; bin2 = bin; iniciar2 = 1'b1;
        @(posedge clk); #1;
        iniciar2 = 1'b0;
        chk({tag, "_busy"}, 64'(oc2), 64'd1);
        chk({tag, "_nopronto"}, 64'(pr2), 64'd0);
        if (chk_b0) chk({tag, "_b0bout"}, 64'(sbout2), 64'd1);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!pr2 && n < 8);
        chk({tag, "_lat"}, 64'(n), 64'd2);
        chk({tag, "_res"}, 64'(res2), 64'(diff[15:0]));
        chk({tag, "_bf"}, 64'(bf2), 64'(diff < 0));
        chk({tag, "_zero"}, 64'(zero2), 64'(diff[15:0] == 16'd0));
        @(posedge clk); #1;
        chk({tag, "_pulse"}, 64'(pr2), 64'd0);
        chk({tag, "_idle"}, 64'(oc2), 64'd0);
    endtask

    initial begin
        logic [15:0] a_hist [0:8];
        int          pulses;
        int          n;
        logic [31:0] a, b;
        logic        bin;
        longint      diff;

        rst_n = 1'b0;
        iniciar2 = 1'b0; op_a2 = '0; op_b2 = '0; bin2 = 1'b0;
        iniciar4 = 1'b0; op_a4 = '0; op_b4 = '0; bin4 = 1'b0;
        #1;
        chk("rst_res", 64'(res4), 64'd0);
        chk("rst_flags", 64'({bf4, zero4, oc4, pr4}), 64'd0);
        chk("rst_sub", 64'({sa4, sb4, sbin4}), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        d2("t1", 16'h1234, 16'h0235, 1'b0, 1'b1);
        d2("t2", 16'h0000, 16'h0001, 1'b0, 1'b0);
        d2("t3", 16'h0100, 16'h0001, 1'b0, 1'b0);
        d2("t4", 16'h0005, 16'h0005, 1'b1, 1'b0);
        d2("t5", 16'h0005, 16'h0005, 1'b0, 1'b0);

        // iniciar held high: accepted at edges 0,3,6, pronto after edges 2,5,8
        pulses = 0;
        iniciar2 = 1'b1; op_b2 = 16'h0101; bin2 = 1'b0;
        for (int c = 0; c < 9; c++) begin
            op_a2 = 16'($urandom);
            a_hist[c] = op_a2;
            @(posedge clk); #1;
            if (pr2) pulses++;
            chk("hold_pronto", 64'(pr2), 64'(c % 3 == 2));
            if (c % 3 == 2) chk("hold_res", 64'(res2), 64'(16'(a_hist[c-2] - 16'h0101)));
        end
        iniciar2 = 1'b0;
        chk("hold_pulses", 64'(pulses), 64'd3);
        @(posedge clk); #1;
        chk("hold_idle", 64'(oc2), 64'd0);

        // reset mid-CALC discards the operation
        op_a4 = 32'h89ABCDEF; op_b4 = 32'h01234567; iniciar4 = 1'b1;
        @(posedge clk); #1;
        iniciar4 = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_res", 64'(res4), 64'd0);
        chk("mid_rst_flags", 64'({bf4, zero4, oc4, pr4}), 64'd0);
        chk("mid_rst_sub", 64'({sa4, sb4, sbin4}), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (pr4) pulses++;
        end
        chk("mid_rst_nopronto", 64'(pulses), 64'd0);
        d2("t6", 16'hFFFF, 16'h0001, 1'b0, 1'b0);

        // random back-to-back regression on N_BYTES=4
        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            b = (i % 16 == 0) ? a : $urandom;
            bin = 1'($urandom_range(0, 1));
            if (i % 16 == 0) bin = 1'b0;
            diff = longint'(a) - longint'(b) - longint'(bin);
            op_a4 = a; op_b4 = b; bin4 = bin; iniciar4 = 1'b1;
            @(posedge clk); #1;
            iniciar4 = 1'b0;
            op_a4 = $urandom; op_b4 = $urandom;
            n = 0;
            do begin
                @(posedge clk); #1;
                n++;
            end while (!pr4 && n < 12);
            chk("rnd_lat", 64'(n), 64'd4);
            chk("rnd_res", 64'(res4), 64'(diff[31:0]));
            chk("rnd_bf", 64'(bf4), 64'(diff < 0));
            chk("rnd_zero", 64'(zero4), 64'(diff[31:0] == 32'd0));
        end
        @(posedge clk); #1;
        chk("rnd_idle", 64'({oc4, pr4}), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
